smem_line_fetch: RTL and testbench

//  Wishbone burst-read master sitting directly upstream of the 128-bit scratchpad RAM.

---
 rtl/smem_line_fetch_if.sv | 42 ++++
 rtl/smem_line_fetch.sv | 161 ++++++++++++++++
 tb/tb_smem_line_fetch.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/smem_line_fetch_if.sv
// smem_line_fetch_if
//  Bundles the two sides of the line fetcher into one interface:
//   - client side : req_i / req_adr_i / req_rdy_o, line_vld_o / line_err_o / line_o / line_ack_i
//   - memory side : Wishbone burst-read bus cs_o, cyc_o, stb_o, we_o, cti_o, sel_o, adr_o,
//                   ack_i, dat_i
//  Signal names carry the fetcher's own direction suffixes so existing code maps 1:1.
//  Modports:
//   master : the fetcher (drives the *_o signals, samples the *_i signals)
//   slave  : the environment (client + scratchpad RAM), the mirror image
//  BEATS must match the BEATS of the attached smem_line_fetch (sets the line width).
interface smem_line_fetch_if #(
  parameter int unsigned BEATS = 4
);
  logic                   req_i;
  logic [15:0]            req_adr_i;
  logic                   req_rdy_o;
  logic                   line_vld_o;
  logic                   line_err_o;
  logic [128*BEATS-1:0]   line_o;
  logic                   line_ack_i;
  logic                   cs_o;
  logic                   cyc_o;
  logic                   stb_o;
  logic                   we_o;
  logic [2:0]             cti_o;
  logic [15:0]            sel_o;
  logic [15:0]            adr_o;
  logic                   ack_i;
  logic [127:0]           dat_i;

  modport master (
    input  req_i, req_adr_i, line_ack_i, ack_i, dat_i,
    output req_rdy_o, line_vld_o, line_err_o, line_o,
           cs_o, cyc_o, stb_o, we_o, cti_o, sel_o, adr_o
  );

  modport slave (
    output req_i, req_adr_i, line_ack_i, ack_i, dat_i,
    input  req_rdy_o, line_vld_o, line_err_o, line_o,
           cs_o, cyc_o, stb_o, we_o, cti_o, sel_o, adr_o
  );
endinterface

// File: rtl/smem_line_fetch.sv
// smem_line_fetch
//  Wishbone burst-read master in front of the 128-bit scratchpad RAM. One accepted
//  line request becomes one incrementing burst of BEATS reads; the beats are assembled
//  into a line buffer and returned on a valid/ack handshake. A burst that sees no
//  ack_i for TIMEOUT consecutive cycles is aborted and the line is flagged as error.
//  Parameters:
//   BEATS   : beats per line, power of two 1..8 (line = BEATS*16 bytes)
//   TIMEOUT : idle burst cycles before abort, 1..65535
//  Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   bus     : smem_line_fetch_if.master (client handshake + Wishbone master signals)
//  All outputs come straight from flops.
module smem_line_fetch #(
  parameter int unsigned BEATS   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  smem_line_fetch_if.master  bus
);

  localparam int unsigned OFS = $clog2(BEATS) + 4;
  localparam int unsigned BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LW  = 128 * BEATS;
  localparam logic [BW-1:0] LAST    = BW'(BEATS - 1);
  localparam logic [15:0]   TMO_END = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t          state_q, state_d;
  logic            rdy_q, rdy_d;
  logic            cyc_q, cyc_d;
  logic            vld_q, vld_d;
  logic            err_q, err_d;
  logic [2:0]      cti_q, cti_d;
  logic [15:0]     adr_q, adr_d;
  logic [15:0]     base_q, base_d;
  logic [15:0]     tmo_q, tmo_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [LW-1:0]   line_q, line_d;

  // Cycle type announced for a given beat index.
  function automatic logic [2:0] cti_of(input logic [BW-1:0] b);
    if (BEATS == 1)     return 3'b000;
    else if (b == LAST) return 3'b111;
    else                return 3'b010;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      cyc_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cti_q   <= '0;
      adr_q   <= '0;
      base_q  <= '0;
      tmo_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      cyc_q   <= cyc_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cti_q   <= cti_d;
      adr_q   <= adr_d;
      base_q  <= base_d;
      tmo_q   <= tmo_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdy_d   = rdy_q;
    cyc_d   = cyc_q;
    vld_d   = vld_q;
    err_d   = err_q;
    cti_d   = cti_q;
    adr_d   = adr_q;
    base_d  = base_q;
    tmo_d   = tmo_q;
    beat_d  = beat_q;
    line_d  = line_q;

    unique case (state_q)
      IDLE: begin
        // rdy_q is still low on the first cycle after reset, so nothing is accepted there.
        if (bus.req_i && rdy_q) begin
          base_d  = {bus.req_adr_i[15:OFS], {OFS{1'b0}}};
          beat_d  = '0;
          tmo_d   = '0;
          adr_d   = base_d;
          cti_d   = cti_of('0);
          cyc_d   = 1'b1;
          rdy_d   = 1'b0;
          state_d = BURST;
        end else begin
          rdy_d = 1'b1;
        end
      end

      BURST: begin
        if (bus.ack_i) begin
          line_d[{beat_q, 7'd0} +: 128] = bus.dat_i;
          tmo_d = '0;
          if (beat_q == LAST) begin
            cyc_d   = 1'b0;
            cti_d   = '0;
            adr_d   = '0;
            vld_d   = 1'b1;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
            adr_d  = base_q | (16'(beat_d) << 4);
            cti_d  = cti_of(beat_d);
          end
        end else if (tmo_q == TMO_END) begin
          // Abort: partial beats stay in the buffer, line is returned flagged.
          cyc_d   = 1'b0;
          cti_d   = '0;
          adr_d   = '0;
          vld_d   = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      DONE: begin
        if (bus.line_ack_i) begin
          vld_d   = 1'b0;
          err_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_rdy_o  = rdy_q;
  assign bus.line_vld_o = vld_q;
  assign bus.line_err_o = err_q;
  assign bus.line_o     = line_q;
  assign bus.cyc_o      = cyc_q;
  assign bus.stb_o      = cyc_q;
  assign bus.cs_o       = cyc_q;
  assign bus.we_o       = 1'b0;
  assign bus.cti_o      = cti_q;
  assign bus.sel_o      = {16{cyc_q}};
  assign bus.adr_o      = adr_q;

endmodule

// File: tb/tb_smem_line_fetch.sv
// tb_smem_line_fetch
//  Drives a 4-beat fetcher (TIMEOUT=8) and a 1-beat fetcher against a scratchpad
//  model (random 4096 x 128-bit array). Expected lines are built from the array at
//  the line-aligned base address; expected latency is beats plus inserted wait states.
module tb_smem_line_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  smem_line_fetch_if #(.BEATS(4)) b4 ();
  smem_line_fetch_if #(.BEATS(1)) b1 ();

  smem_line_fetch #(.BEATS(4), .TIMEOUT(8)) dut4 (.clk_i(clk), .rst_i(rst), .bus(b4.master));
  smem_line_fetch #(.BEATS(1), .TIMEOUT(8)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1.master));

  logic [127:0] mem [4096];
  logic [511:0] exp_line;
  bit           chk_line;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One burst on the 4-beat fetcher. wmode<0: random 0..2 wait states per beat,
  // else a fixed count. nack: beats acked before the slave goes silent.
  task automatic fetch4(input logic [15:0] a, input int wmode, input int nack, input bit expect_to);
    logic [15:0] base;
    int k, w, waits, edges, idle;
    base = a & 16'hFFC0;
    for (int i = 0; i < 4; i++) exp_line[128*i +: 128] = mem[(base >> 4) + 16'(i)];
    chk_line = (nack == 4);
    b4.req_i = 1'b1;
    b4.req_adr_i = a;
    w = 0;
    while (b4.req_rdy_o !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    check("req_rdy_idle", b4.req_rdy_o, 1);
    @(negedge clk);
    b4.req_i = 1'b0;
    b4.req_adr_i = 16'($urandom);
    check("burst_start", {b4.cyc_o, b4.req_rdy_o}, 2'b10);
    k = 0;
    w = (wmode < 0) ? int'($urandom_range(0, 2)) : wmode;
    waits = w;
    edges = 0;
    while (k < nack) begin
      check("bus_ctl", {b4.cyc_o, b4.stb_o, b4.cs_o, b4.we_o, b4.line_vld_o, b4.sel_o},
            {5'b11100, 16'hFFFF});
      if (w > 0) begin
        b4.ack_i = 1'b0;
        b4.dat_i = rnd128();
        w--;
      end else begin
        check("adr", b4.adr_o, base + 16'(16 * k));
        check("cti", b4.cti_o, (k == 3) ? 3'b111 : 3'b010);
        b4.ack_i = 1'b1;
        b4.dat_i = mem[b4.adr_o[15:4]];
        k++;
        if (k < nack) begin
          w = (wmode < 0) ? int'($urandom_range(0, 2)) : wmode;
          waits += w;
        end
      end
      @(negedge clk);
      edges++;
    end
    b4.ack_i = 1'b0;
    if (nack == 4) begin
      check("latency", edges, 4 + waits);
      check("done_flags", {b4.line_vld_o, b4.line_err_o, b4.cyc_o, b4.sel_o, b4.req_rdy_o},
            {3'b100, 16'h0, 1'b0});
      check("line", b4.line_o, exp_line);
    end else if (expect_to) begin
      idle = 0;
      while (b4.cyc_o === 1'b1 && idle < 40) begin
        b4.ack_i = 1'b0;
        @(negedge clk);
        idle++;
      end
      check("timeout_cycles", idle, 8);
      check("timeout_flags", {b4.line_vld_o, b4.line_err_o, b4.cyc_o}, 3'b110);
    end
  endtask

  // Hold the finished line for `hold` cycles (optionally with stray acks and a held
  // request), then acknowledge it.
  task automatic finish4(input int hold, input bit stray, input bit hold_req, input bit err);
    for (int i = 0; i < hold; i++) begin
      check("hold_flags", {b4.line_vld_o, b4.line_err_o, b4.cyc_o, b4.req_rdy_o},
            {1'b1, err, 2'b00});
      if (chk_line) check("hold_line", b4.line_o, exp_line);
      b4.ack_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      b4.dat_i = rnd128();
      b4.req_i = hold_req;
      b4.req_adr_i = 16'($urandom);
      @(negedge clk);
    end
    b4.ack_i = 1'b0;
    b4.line_ack_i = 1'b1;
    @(negedge clk);
    b4.line_ack_i = 1'b0;
    check("after_ack", {b4.line_vld_o, b4.line_err_o, b4.req_rdy_o, b4.cyc_o}, 4'b0010);
    if (chk_line) check("line_kept", b4.line_o, exp_line);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = rnd128();
    b4.req_i = 0; b4.req_adr_i = '0; b4.line_ack_i = 0; b4.ack_i = 0; b4.dat_i = '0;
    b1.req_i = 0; b1.req_adr_i = '0; b1.line_ack_i = 0; b1.ack_i = 0; b1.dat_i = '0;

    // Reset state
    #3;
    check("rst4_outs", {b4.cyc_o, b4.stb_o, b4.cs_o, b4.we_o, b4.line_vld_o, b4.line_err_o,
                        b4.req_rdy_o, b4.cti_o, b4.sel_o, b4.adr_o}, '0);
    check("rst4_line", b4.line_o, '0);
    check("rst1_outs", {b1.cyc_o, b1.line_vld_o, b1.req_rdy_o, b1.line_o}, '0);
    @(negedge clk);
    rst = 1'b0;
    check("rdy_low_at_release", b4.req_rdy_o, 0);
    @(negedge clk);
    check("rdy_first_clk", {b4.req_rdy_o, b1.req_rdy_o}, 2'b11);

    // Zero-wait burst
    fetch4(16'h1234, 0, 4, 0);
    finish4(0, 0, 0, 0);

    // One wait state before every beat
    fetch4(16'h1234, 1, 4, 0);
    finish4(2, 0, 0, 0);

    // Slave goes silent after two beats
    fetch4(16'h1234, 0, 2, 1);
    finish4(3, 0, 0, 1);

    // Async reset after beat 1
    fetch4(16'h5678, 0, 2, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_outs", {b4.cyc_o, b4.stb_o, b4.cs_o, b4.line_vld_o, b4.line_err_o,
                          b4.req_rdy_o, b4.cti_o, b4.sel_o, b4.adr_o}, '0);
    check("midrst_line", b4.line_o, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_midrst", b4.req_rdy_o, 1);
    fetch4(16'h9ABC, 0, 4, 0);
    finish4(0, 0, 0, 0);

    // Line held 20 cycles with request pending and stray acks; next burst follows
    fetch4(16'h0FC0, 0, 4, 0);
    finish4(20, 1, 1, 0);
    fetch4(16'h4321, -1, 4, 0);
    finish4(1, 0, 0, 0);

    // Random addresses and wait states
    for (int r = 0; r < 10; r++) begin
      fetch4(16'($urandom), -1, 4, 0);
      finish4(int'($urandom_range(0, 4)), 1, 1'($urandom_range(0, 1)), 0);
    end

    // Single-beat fetcher
    for (int r = 0; r < 4; r++) begin
      logic [15:0] a;
      a = (r == 0) ? 16'hFFFF : 16'($urandom);
      b1.req_i = 1'b1;
      b1.req_adr_i = a;
      @(negedge clk);
      b1.req_i = 1'b0;
      check("b1_bus", {b1.cyc_o, b1.sel_o, b1.cti_o, b1.adr_o},
            {1'b1, 16'hFFFF, 3'b000, a & 16'hFFF0});
      b1.ack_i = 1'b1;
      b1.dat_i = mem[b1.adr_o[15:4]];
      @(negedge clk);
      b1.ack_i = 1'b0;
      check("b1_done", {b1.line_vld_o, b1.line_err_o, b1.cyc_o}, 3'b100);
      check("b1_line", b1.line_o, mem[a[15:4]]);
      b1.line_ack_i = 1'b1;
      @(negedge clk);
      b1.line_ack_i = 1'b0;
      check("b1_idle", {b1.line_vld_o, b1.req_rdy_o}, 2'b01);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
